// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// spi_slave
//   SPI peripheral end of the link. Everything runs on the system clock:
//   SCLK, CS_N and MOSI are oversampled through synchroniser chains, and edges
//   are detected against one extra delay register. MOSI is deserialised into
//   bytes, and a byte supplied by the higher-level module is serialised onto
//   MISO. The SPI mode (CPOL/CPHA) is fixed by a parameter.
//
// Parameters
//   c_SPI_MODE     SPI mode 0..3 (CPOL = mode[1], CPHA = mode[0])
//   c_SYNC_STAGES  synchroniser depth on the SPI inputs (>= 2)
//   c_DEFAULT_TX   byte shifted out when no TX byte is pending
//
// Ports
//   i_CLK          system clock
//   i_RESET_N      asynchronous reset, active-low
//   i_TX_BYTE      byte to return to the master
//   i_TX_DV        i_TX_BYTE valid, accepted while o_TX_READY=1
//   o_TX_READY     TX holding register empty
//   o_TX_UNDERRUN  1-cycle pulse: a byte load found the holding register empty
//   o_RX_DV        1-cycle pulse: o_RX_BYTE updated
//   o_RX_BYTE      last complete received byte (MSb first on the wire)
//   i_SPI_CLK      SCLK from the master
//   i_SPI_CS_N     chip select, active-low
//   i_SPI_MOSI     master out
//   o_SPI_MISO     slave out (MSb of the TX shift register)
//   o_SPI_MISO_OE  MISO tri-state enable, high only while selected
// ----------------------------------------------------------------------------
module spi_slave #(
    parameter int         c_SPI_MODE    = 3,
    parameter int         c_SYNC_STAGES = 2,
    parameter logic [7:0] c_DEFAULT_TX  = 8'hFF
) (
    input  logic       i_CLK,
    input  logic       i_RESET_N,
    input  logic [7:0] i_TX_BYTE,
    input  logic       i_TX_DV,
    output logic       o_TX_READY,
    output logic       o_TX_UNDERRUN,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_BYTE,
    input  logic       i_SPI_CLK,
    input  logic       i_SPI_CS_N,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_OE
);

    localparam logic CPOL = (c_SPI_MODE == 2) || (c_SPI_MODE == 3);
    localparam logic CPHA = (c_SPI_MODE == 1) || (c_SPI_MODE == 3);

    // Bit 2 = SCLK, bit 1 = CS_N, bit 0 = MOSI. Reset values keep the
    // synchronised view at the idle bus level so no edge is seen on release.
    localparam logic [2:0] SYNC_RST = {CPOL, 1'b1, 1'b0};

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic [2:0] pin_in;
    logic [2:0] synced;

    assign pin_in = {i_SPI_CLK, i_SPI_CS_N, i_SPI_MOSI};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [c_SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge i_CLK or negedge i_RESET_N) begin
                if (!i_RESET_N) begin
                    chain_reg <= {c_SYNC_STAGES{SYNC_RST[gi]}};
                end else begin
                    chain_reg <= {chain_reg[c_SYNC_STAGES-2:0], pin_in[gi]};
                end
            end

            assign synced[gi] = chain_reg[c_SYNC_STAGES-1];
        end
    endgenerate

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    assign sclk_s = synced[2];
    assign cs_s   = synced[1];
    assign mosi_s = synced[0];

    // One extra register on SCLK and CS_N for edge detection.
    logic sclk_d_reg;
    logic cs_d_reg;

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            sclk_d_reg <= CPOL;
            cs_d_reg   <= 1'b1;
        end else begin
            sclk_d_reg <= sclk_s;
            cs_d_reg   <= cs_s;
        end
    end

    logic leading_edge;
    logic trailing_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic cs_rise;

    assign leading_edge  = (sclk_d_reg == CPOL) && (sclk_s != CPOL);
    assign trailing_edge = (sclk_d_reg != CPOL) && (sclk_s == CPOL);
    assign sample_edge   = CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = CPHA ? leading_edge  : trailing_edge;
    assign cs_fall       = cs_d_reg && !cs_s;
    assign cs_rise       = !cs_d_reg && cs_s;

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] rx_shift_reg;
    logic [7:0] tx_shift_reg;
    logic [7:0] holding_reg;
    logic       holding_full_reg;
    logic [7:0] rx_byte_reg;
    logic       rx_dv_reg;
    logic       underrun_reg;
    logic       miso_oe_reg;

    logic active;
    logic do_sample;
    logic do_load;
    logic do_shift;
    logic tx_accept;

    // SCLK edges that coincide with CS_N rising are part of deselect and are
    // not acted on.
    assign active    = (state_reg == ST_ACTIVE) && !cs_rise;
    assign do_sample = active && sample_edge;
    assign do_load   = (!CPHA && (state_reg == ST_IDLE) && cs_fall)
                     || (active && shift_edge && (bit_cnt_reg == 3'd0));
    assign do_shift  = active && shift_edge && (bit_cnt_reg != 3'd0);
    assign tx_accept = i_TX_DV && !holding_full_reg;

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= 3'd0;
            rx_shift_reg     <= 8'h00;
            tx_shift_reg     <= c_DEFAULT_TX;
            holding_reg      <= 8'h00;
            holding_full_reg <= 1'b0;
            rx_byte_reg      <= 8'h00;
            rx_dv_reg        <= 1'b0;
            underrun_reg     <= 1'b0;
            miso_oe_reg      <= 1'b0;
        end else begin
            rx_dv_reg    <= 1'b0;
            underrun_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_reg    <= ST_ACTIVE;
                        miso_oe_reg  <= 1'b1;
                        bit_cnt_reg  <= 3'd0;
                        rx_shift_reg <= 8'h00;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        // A partial byte is discarded; the TX byte already
                        // in the shifter counts as consumed.
                        state_reg    <= ST_IDLE;
                        miso_oe_reg  <= 1'b0;
                        bit_cnt_reg  <= 3'd0;
                        rx_shift_reg <= 8'h00;
                    end else if (do_sample) begin
                        rx_shift_reg <= {rx_shift_reg[6:0], mosi_s};
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_byte_reg <= {rx_shift_reg[6:0], mosi_s};
                            rx_dv_reg   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    miso_oe_reg <= 1'b0;
                end
            endcase

            if (do_load) begin
                if (holding_full_reg) begin
                    tx_shift_reg     <= holding_reg;
                    holding_full_reg <= 1'b0;
                end else if (tx_accept) begin
                    // Byte arrives just in time: bypass the holding register.
                    tx_shift_reg <= i_TX_BYTE;
                end else begin
                    tx_shift_reg <= c_DEFAULT_TX;
                    underrun_reg <= 1'b1;
                end
            end else begin
                if (do_shift) begin
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                end
                if (tx_accept) begin
                    holding_reg      <= i_TX_BYTE;
                    holding_full_reg <= 1'b1;
                end
            end
        end
    end

    assign o_TX_READY    = !holding_full_reg;
    assign o_TX_UNDERRUN = underrun_reg;
    assign o_RX_DV       = rx_dv_reg;
    assign o_RX_BYTE     = rx_byte_reg;
    assign o_SPI_MISO    = tx_shift_reg[7];
    assign o_SPI_MISO_OE = miso_oe_reg;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Testbench for spi_slave: one mode-3 instance and one mode-0 instance on
// separate SPI buses. Received bytes are checked by scoreboard monitors.
module tb_spi_slave;

    localparam int HALF = 8;   // SCLK half-period in system clock cycles

    logic clk;
    logic rst_n;

    // Mode 3 instance
    logic [7:0] tx_byte3;
    logic       tx_dv3;
    logic       ready3;
    logic       und3;
    logic       rxdv3;
    logic [7:0] rxb3;
    logic       sclk3;
    logic       csn3;
    logic       mosi3;
    logic       miso3;
    logic       oe3;

    // Mode 0 instance
    logic [7:0] tx_byte0;
    logic       tx_dv0;
    logic       ready0;
    logic       und0;
    logic       rxdv0;
    logic [7:0] rxb0;
    logic       sclk0;
    logic       csn0;
    logic       mosi0;
    logic       miso0;
    logic       oe0;

    spi_slave #(.c_SPI_MODE(3), .c_SYNC_STAGES(2), .c_DEFAULT_TX(8'hFF)) u_dut3 (
        .i_CLK         (clk),
        .i_RESET_N     (rst_n),
        .i_TX_BYTE     (tx_byte3),
        .i_TX_DV       (tx_dv3),
        .o_TX_READY    (ready3),
        .o_TX_UNDERRUN (und3),
        .o_RX_DV       (rxdv3),
        .o_RX_BYTE     (rxb3),
        .i_SPI_CLK     (sclk3),
        .i_SPI_CS_N    (csn3),
        .i_SPI_MOSI    (mosi3),
        .o_SPI_MISO    (miso3),
        .o_SPI_MISO_OE (oe3)
    );

    spi_slave #(.c_SPI_MODE(0), .c_SYNC_STAGES(2), .c_DEFAULT_TX(8'hFF)) u_dut0 (
        .i_CLK         (clk),
        .i_RESET_N     (rst_n),
        .i_TX_BYTE     (tx_byte0),
        .i_TX_DV       (tx_dv0),
        .o_TX_READY    (ready0),
        .o_TX_UNDERRUN (und0),
        .o_RX_DV       (rxdv0),
        .o_RX_BYTE     (rxb0),
        .i_SPI_CLK     (sclk0),
        .i_SPI_CS_N    (csn0),
        .i_SPI_MOSI    (mosi0),
        .o_SPI_MISO    (miso0),
        .o_SPI_MISO_OE (oe0)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;   // 50 MHz

    int n_total = 0;
    int n_pass  = 0;
    int und3_cnt = 0;
    int und0_cnt = 0;

    logic [7:0] q3[$];
    logic [7:0] q0[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every o_RX_DV pulse must match the next queued byte.
    always @(negedge clk) begin
        if (rxdv3 === 1'b1) begin
            if (q3.size() == 0) begin
                n_total++;
                $display("FAIL rx3_unexpected: got pulse with byte %0h expected no pulse", rxb3);
            end else begin
                logic [7:0] e;
                e = q3.pop_front();
                chk("rx3_byte", {24'd0, rxb3}, {24'd0, e});
                $display("rx3 byte %0h expected %0h", rxb3, e);
            end
        end
        if (rxdv0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL rx0_unexpected: got pulse with byte %0h expected no pulse", rxb0);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                chk("rx0_byte", {24'd0, rxb0}, {24'd0, e});
                $display("rx0 byte %0h expected %0h", rxb0, e);
            end
        end
        if (und3 === 1'b1) und3_cnt++;
        if (und0 === 1'b1) und0_cnt++;
    end

    // Write a TX byte to the mode-3 instance once it is ready (bounded wait).
    task automatic wr3(input logic [7:0] b);
        int k;
        k = 0;
        while (ready3 !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wr3_ready", {31'd0, ready3}, 32'd1);
        tx_byte3 = b;
        tx_dv3   = 1'b1;
        @(negedge clk);
        tx_dv3   = 1'b0;
    endtask

    task automatic cs3(input logic v);
        csn3 = v;
        repeat (HALF) @(negedge clk);
    endtask

    // Mode 3 master: drive on falling SCLK, sample MISO on rising SCLK.
    // With inj=1, i_TX_DV is raised exactly in the cycle the slave acts on
    // the first falling edge (pin + 2 sync stages + edge register).
    task automatic xfer3(input logic [7:0] b, input int nbits, input logic inj,
                         input logic [7:0] injb, output logic [7:0] got);
        logic [7:0] sh;
        sh  = b;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sclk3 = 1'b0;
            mosi3 = sh[7];
            sh    = {sh[6:0], 1'b0};
            if (inj && i == 0) begin
                @(negedge clk);
                @(negedge clk);
                tx_byte3 = injb;
                tx_dv3   = 1'b1;
                @(negedge clk);
                tx_dv3   = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk3 = 1'b1;
            got   = {got[6:0], miso3};
            repeat (HALF) @(negedge clk);
        end
    endtask

    // Mode 0 master, whole single-byte frame including CS. Reports how many
    // underrun pulses occurred between CS_N fall and the first SCLK edge.
    task automatic xfer0(input logic [7:0] b, output logic [7:0] got, output int und_start);
        logic [7:0] sh;
        int u;
        sh  = b;
        got = 8'h00;
        u   = und0_cnt;
        csn0  = 1'b0;
        mosi0 = sh[7];
        sh    = {sh[6:0], 1'b0};
        repeat (HALF) @(negedge clk);
        und_start = und0_cnt - u;
        chk("t3_oe_active", {31'd0, oe0}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            sclk0 = 1'b1;
            got   = {got[6:0], miso0};
            repeat (HALF) @(negedge clk);
            sclk0 = 1'b0;
            mosi0 = sh[7];
            sh    = {sh[6:0], 1'b0};
            repeat (HALF) @(negedge clk);
        end
        csn0 = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got;
        int u;
        int ub;

        rst_n    = 1'b0;
        tx_byte3 = 8'h00; tx_dv3 = 1'b0; sclk3 = 1'b1; csn3 = 1'b1; mosi3 = 1'b0;
        tx_byte0 = 8'h00; tx_dv0 = 1'b0; sclk0 = 1'b0; csn0 = 1'b1; mosi0 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_ready3", {31'd0, ready3}, 32'd1);
        chk("rst_und3",   {31'd0, und3},   32'd0);
        chk("rst_rxdv3",  {31'd0, rxdv3},  32'd0);
        chk("rst_rxb3",   {24'd0, rxb3},   32'h00);
        chk("rst_oe3",    {31'd0, oe3},    32'd0);
        chk("rst_miso3",  {31'd0, miso3},  32'd1);
        chk("rst_oe0",    {31'd0, oe0},    32'd0);
        chk("rst_miso0",  {31'd0, miso0},  32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // T1: mode 3 single byte, TX preloaded
        wr3(8'h3C);
        chk("t1_ready_low", {31'd0, ready3}, 32'd0);
        cs3(1'b0);
        chk("t1_oe_active", {31'd0, oe3}, 32'd1);
        q3.push_back(8'hA5);
        xfer3(8'hA5, 8, 1'b0, 8'h00, got);
        $display("t1 miso %0h expected 3c", got);
        chk("t1_miso", {24'd0, got}, 32'h3C);
        chk("t1_ready_back", {31'd0, ready3}, 32'd1);
        cs3(1'b1);
        chk("t1_oe_idle", {31'd0, oe3}, 32'd0);
        chk("t1_rxb_hold", {24'd0, rxb3}, 32'hA5);

        // T2: mode 3 three-byte frame, TX refilled between bytes
        wr3(8'h11);
        cs3(1'b0);
        q3.push_back(8'h01);
        xfer3(8'h01, 8, 1'b0, 8'h00, got);
        $display("t2 miso %0h expected 11", got);
        chk("t2_miso0", {24'd0, got}, 32'h11);
        wr3(8'h22);
        q3.push_back(8'h80);
        xfer3(8'h80, 8, 1'b0, 8'h00, got);
        $display("t2 miso %0h expected 22", got);
        chk("t2_miso1", {24'd0, got}, 32'h22);
        wr3(8'h33);
        q3.push_back(8'hFF);
        xfer3(8'hFF, 8, 1'b0, 8'h00, got);
        $display("t2 miso %0h expected 33", got);
        chk("t2_miso2", {24'd0, got}, 32'h33);
        cs3(1'b1);

        // T3: mode 0, nothing written -> default byte and underrun at CS fall
        q0.push_back(8'h5A);
        xfer0(8'h5A, got, u);
        $display("t3 miso %0h expected ff, underrun at cs fall %0d", got, u);
        chk("t3_miso", {24'd0, got}, 32'hFF);
        chk("t3_und_at_cs", u, 32'd1);
        chk("t3_rxb", {24'd0, rxb0}, 32'h5A);
        chk("t3_oe_idle", {31'd0, oe0}, 32'd0);

        // T4: mode 3 partial frame (5 bits) then a full frame
        cs3(1'b0);
        xfer3(8'hF0, 5, 1'b0, 8'h00, got);
        cs3(1'b1);
        chk("t4_oe_idle", {31'd0, oe3}, 32'd0);
        chk("t4_rxb_kept", {24'd0, rxb3}, 32'hFF);
        cs3(1'b0);
        q3.push_back(8'hC3);
        xfer3(8'hC3, 8, 1'b0, 8'h00, got);
        $display("t4 miso %0h expected ff", got);
        chk("t4_miso", {24'd0, got}, 32'hFF);
        cs3(1'b1);
        chk("t4_rxb", {24'd0, rxb3}, 32'hC3);

        // T5: reset after bit 4, then a full frame
        cs3(1'b0);
        xfer3(8'h0F, 4, 1'b0, 8'h00, got);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_ready",  {31'd0, ready3}, 32'd1);
        chk("t5_und",    {31'd0, und3},   32'd0);
        chk("t5_rxdv",   {31'd0, rxdv3},  32'd0);
        chk("t5_rxb",    {24'd0, rxb3},   32'h00);
        chk("t5_oe",     {31'd0, oe3},    32'd0);
        chk("t5_miso",   {31'd0, miso3},  32'd1);
        csn3 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        cs3(1'b0);
        q3.push_back(8'h96);
        xfer3(8'h96, 8, 1'b0, 8'h00, got);
        chk("t5_miso_frame", {24'd0, got}, 32'hFF);
        cs3(1'b1);
        chk("t5_rxb_frame", {24'd0, rxb3}, 32'h96);

        // T6: TX byte accepted in the same cycle as the first shift edge
        ub = und3_cnt;
        cs3(1'b0);
        q3.push_back(8'h42);
        xfer3(8'h42, 8, 1'b1, 8'h7E, got);
        $display("t6 miso %0h expected 7e, underruns %0d", got, und3_cnt - ub);
        chk("t6_miso", {24'd0, got}, 32'h7E);
        chk("t6_no_underrun", und3_cnt - ub, 32'd0);
        chk("t6_ready", {31'd0, ready3}, 32'd1);
        cs3(1'b1);

        repeat (4) @(negedge clk);
        chk("q3_drained", q3.size(), 32'd0);
        chk("q0_drained", q0.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (slave) end of the link driven by the SPI master block; runs entirely in the system clock domain (50 MHz).
- Oversamples SCLK, CS_N and MOSI, and deserialises MOSI into bytes for the higher-level module.
- Serialises a byte supplied by the higher-level module onto MISO, e.g. the controller button state.
- Mode selectable (CPOL/CPHA); default mode 3 to match the master.

Parameters:
c_SPI_MODE, 3, SPI mode 0-3; CPOL = (mode==2|3), CPHA = (mode==1|3)
c_SYNC_STAGES, 2, synchroniser flops on i_SPI_CLK, i_SPI_CS_N, i_SPI_MOSI (min 2)
c_DEFAULT_TX, 8'hFF, byte shifted out when no TX byte is pending

Ports:
i_CLK  in  1  system clock
i_RESET_N  in  1  asynchronous reset, active-low
i_TX_BYTE  in  8  byte to return to master
i_TX_DV  in  1  i_TX_BYTE valid; accepted when o_TX_READY=1
o_TX_READY  out  1  TX holding register empty
o_TX_UNDERRUN  out  1  1-cycle pulse: byte load found holding empty, c_DEFAULT_TX sent
o_RX_DV  out  1  1-cycle pulse: o_RX_BYTE updated
o_RX_BYTE  out  8  last complete received byte, MSb first on wire
i_SPI_CLK  in  1  SCLK from master
i_SPI_CS_N  in  1  chip select, active-low
i_SPI_MOSI  in  1  master out
o_SPI_MISO  out  1  slave out (= tx_shift[7])
o_SPI_MISO_OE  out  1  MISO tri-state enable; high only while CS is asserted

Behaviour:
- Reset (i_RESET_N=0, async):
  - Sync chains: SCLK←CPOL, CS_N←1, MOSI←0.
  - Bit counter 0, rx_shift 0, tx_shift←c_DEFAULT_TX, holding empty, state IDLE.
  - Outputs: o_TX_READY=1, o_TX_UNDERRUN=0, o_RX_DV=0, o_RX_BYTE=0, o_SPI_MISO_OE=0, o_SPI_MISO=c_DEFAULT_TX[7].
- Synchronisation and edge detection:
  - Each input passes c_SYNC_STAGES flops; one extra register on SCLK and CS_N provides edge detection.
  - Pin-to-detected-edge latency is c_SYNC_STAGES+1 i_CLK cycles.
  - Leading edge = synced SCLK leaves CPOL level; trailing edge = returns to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
  - Edges are ignored in IDLE.
- Clock ratio: SCLK half-period must be ≥ c_SYNC_STAGES+2 i_CLK cycles, i.e. ≤ 6.25 MHz SCLK at 50 MHz with defaults. Behaviour above this rate is undefined.
- State machine:
  - IDLE→ACTIVE on synced CS_N falling edge. ACTIVE→IDLE on synced CS_N rising edge.
  - o_SPI_MISO_OE = (state==ACTIVE), registered.
- RX path:
  - On each sample edge: rx_shift←{rx_shift[6:0], mosi_sync}; bit counter +1 (3-bit, wraps 7→0).
  - On the sample edge where the counter wraps 7→0, the next cycle drives o_RX_BYTE←completed byte and o_RX_DV=1 for exactly one cycle.
  - o_RX_BYTE holds its value until the next complete byte.
- TX holding register:
  - i_TX_DV while o_TX_READY=1 stores the byte; o_TX_READY goes 0 the next cycle.
  - i_TX_DV while o_TX_READY=0 is ignored; no overwrite.
- Byte load events:
  - CPHA=0: CS_N falling edge, or a shift edge with bit counter==0.
  - CPHA=1: a shift edge with bit counter==0.
  - On a load event, tx_shift←holding and o_TX_READY←1 next cycle.
  - If the holding register is empty, tx_shift←c_DEFAULT_TX and o_TX_UNDERRUN pulses for 1 cycle.
  - If i_TX_DV is accepted in the same cycle as a load event with holding empty, i_TX_BYTE bypasses directly to tx_shift. No underrun; holding stays empty.
- Other shift edges: tx_shift←{tx_shift[6:0], 1'b0}.
- CS_N rising mid-byte:
  - Bit counter←0; partial rx_shift discarded, no o_RX_DV.
  - The byte in tx_shift counts as consumed; the holding register is untouched.
- CPHA=0, last byte of a frame: the trailing edge after the 8th sample loads the next byte. That byte is consumed even if CS_N then rises; o_TX_READY rises accordingly.
- Reset mid-frame: all state returns to reset values immediately. The frame resumes only after a fresh CS_N falling edge.

Test Plan:
- Mode 3, one CS frame, master sends 8'hA5, i_TX_BYTE=8'h3C preloaded → o_RX_BYTE=8'hA5 with a single o_RX_DV pulse; master receives 8'h3C; o_TX_READY returns 1 after the first shift edge.
- Mode 3, 3-byte frame (8'h01, 8'h80, 8'hFF) with new TX bytes 8'h11/22/33 written on each o_TX_READY → three o_RX_DV pulses with matching values; master reads 8'h11, 8'h22, 8'h33.
- Mode 0, no TX byte written, master sends 8'h5A → MISO shows 8'hFF, o_TX_UNDERRUN pulses once at CS_N fall, o_RX_BYTE=8'h5A.
- Mode 3, CS_N deasserted after 5 SCLK cycles, then a full frame sending 8'hC3 → no o_RX_DV for the partial byte, then o_RX_BYTE=8'hC3; o_SPI_MISO_OE=0 whenever CS_N is high.
- Assert i_RESET_N=0 after bit 4 of a byte, release, run a full frame with 8'h96 → outputs at reset values during reset, next frame o_RX_BYTE=8'h96, no spurious o_RX_DV.
- i_TX_DV=1 with 8'h7E in the same cycle as the CPHA=1 first shift edge with holding empty → master reads 8'h7E, no o_TX_UNDERRUN.
